// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  // Canonical NOP (addi x0, x0, 0) that flush consumers load into a cleared stage.
  localparam logic [REG_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PIPE_RUN      = 2'b00,
    PIPE_MEM_WAIT = 2'b01,
    PIPE_DRAIN    = 2'b10
  } pipe_state_e;

  // Per-stage control bundle produced each cycle by the controller.
  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic hold_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
    logic jump;
    logic mem_err;
  } pipe_ctl_t;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [REG_W-1:0] seq_pc(input logic [REG_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EX. Register x0 never creates a hazard.
module pipe_ctrl_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic                  ex_rmem,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign load_use = ex_rmem & ex_wen & (ex_rd_addr != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Resolves memory stalls
// (with timeout), EX redirects, FENCE.I drain and load-use hazards, in that
// priority order. Controls are combinational; only state and counters are flops.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_fence,
  input  logic [REG_W-1:0]      id_pc,
  input  logic                  ex_rmem,
  input  logic                  ex_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_jump,
  input  logic [REG_W-1:0]      ex_jump_addr,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  hold_id_ex,
  output logic                  hold_ex_mem,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_mem_wb,
  output logic                  jump_o,
  output logic [REG_W-1:0]      jump_addr_o,
  output logic                  mem_err,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam int                  DRAIN_W     = $clog2(DRAIN_CYCLES + 1);
  localparam logic [15:0]         TMO_LIMIT   = 16'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0]  DRAIN_LIMIT = DRAIN_W'(DRAIN_CYCLES);

  pipe_state_e        state_q, state_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  pipe_ctl_t          ctl;
  logic [REG_W-1:0]   jump_addr_c;
  logic               load_use;
  logic               mem_stall;
  logic               run_like;

  assign mem_stall = mem_req & ~mem_ready;

  pipe_ctrl_hazard_det hazard_det (
    .ex_rmem     (ex_rmem),
    .ex_wen      (ex_wen),
    .ex_rd_addr  (ex_rd_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_used (id_rs2_used),
    .id_rs2_addr (id_rs2_addr),
    .load_use    (load_use)
  );

  // State and counter registers; reset abandons any pending stall or drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PIPE_RUN;
      tmo_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state and control decode; a MEM_WAIT release cycle is decoded like RUN
  // so a held EX jump or a waiting FENCE.I is acted on as soon as the bus is done.
  always_comb begin
    ctl         = '0;
    jump_addr_c = '0;
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    drain_cnt_d = drain_cnt_q;
    run_like    = 1'b0;

    case (state_q)
      PIPE_MEM_WAIT: begin
        if (mem_ready) begin
          state_d   = PIPE_RUN;
          tmo_cnt_d = '0;
          run_like  = 1'b1;
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          ctl.mem_err = 1'b1;
          state_d     = PIPE_RUN;
          tmo_cnt_d   = '0;
        end else begin
          ctl.hold_pc      = 1'b1;
          ctl.hold_if_id   = 1'b1;
          ctl.hold_id_ex   = 1'b1;
          ctl.hold_ex_mem  = 1'b1;
          ctl.flush_mem_wb = 1'b1;
          tmo_cnt_d        = tmo_cnt_q + 16'd1;
        end
      end
      PIPE_DRAIN: begin
        if (mem_stall) begin
          ctl.hold_pc      = 1'b1;
          ctl.hold_if_id   = 1'b1;
          ctl.hold_id_ex   = 1'b1;
          ctl.hold_ex_mem  = 1'b1;
          ctl.flush_mem_wb = 1'b1;
        end else if (drain_cnt_q == DRAIN_LIMIT) begin
          ctl.jump        = 1'b1;
          ctl.flush_if_id = 1'b1;
          jump_addr_c     = seq_pc(id_pc);
          state_d         = PIPE_RUN;
          drain_cnt_d     = '0;
        end else begin
          ctl.hold_pc     = 1'b1;
          ctl.hold_if_id  = 1'b1;
          ctl.flush_id_ex = 1'b1;
          drain_cnt_d     = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: run_like = 1'b1;
    endcase

    if (run_like) begin
      if (mem_stall) begin
        ctl.hold_pc      = 1'b1;
        ctl.hold_if_id   = 1'b1;
        ctl.hold_id_ex   = 1'b1;
        ctl.hold_ex_mem  = 1'b1;
        ctl.flush_mem_wb = 1'b1;
        state_d          = PIPE_MEM_WAIT;
        tmo_cnt_d        = 16'd1;
      end else if (ex_jump) begin
        ctl.jump        = 1'b1;
        ctl.flush_if_id = 1'b1;
        ctl.flush_id_ex = 1'b1;
        jump_addr_c     = ex_jump_addr;
      end else if (id_fence) begin
        ctl.hold_pc     = 1'b1;
        ctl.hold_if_id  = 1'b1;
        ctl.flush_id_ex = 1'b1;
        state_d         = PIPE_DRAIN;
        drain_cnt_d     = DRAIN_W'(1);
      end else if (load_use) begin
        ctl.hold_pc     = 1'b1;
        ctl.hold_if_id  = 1'b1;
        ctl.flush_id_ex = 1'b1;
      end
    end
  end

  // All controls read zero while reset is held, whatever the inputs are doing.
  assign hold_pc      = ~rst & ctl.hold_pc;
  assign hold_if_id   = ~rst & ctl.hold_if_id;
  assign hold_id_ex   = ~rst & ctl.hold_id_ex;
  assign hold_ex_mem  = ~rst & ctl.hold_ex_mem;
  assign flush_if_id  = ~rst & ctl.flush_if_id;
  assign flush_id_ex  = ~rst & ctl.flush_id_ex;
  assign flush_mem_wb = ~rst & ctl.flush_mem_wb;
  assign jump_o       = ~rst & ctl.jump;
  assign jump_addr_o  = rst ? '0 : jump_addr_c;
  assign mem_err      = ~rst & ctl.mem_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running stall and redirect counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (hold_pc) perf_stall_q <= perf_stall_q + 32'd1;
      if (jump_o)  perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: load-use, redirects, memory wait and timeout,
// FENCE.I drain (including address wrap and stall pause) and async reset.
// Perf-counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_addr = '0;
  logic [4:0]  id_rs2_addr = '0;
  logic        id_rs1_used = 1'b0;
  logic        id_rs2_used = 1'b0;
  logic        id_fence = 1'b0;
  logic [31:0] id_pc = '0;
  logic        ex_rmem = 1'b0;
  logic        ex_wen = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_jump = 1'b0;
  logic [31:0] ex_jump_addr = 32'h8000_0100;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
  logic        flush_if_id, flush_id_ex, flush_mem_wb;
  logic        jump_o, mem_err;
  logic [31:0] jump_addr_o, perf_stall_cnt, perf_flush_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_stall = '0;
  logic [31:0] exp_flush = '0;

  // Control vectors: {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1111001;
  localparam logic [6:0] C_HAZ   = 7'b1100010;
  localparam logic [6:0] C_JMP   = 7'b0000110;
  localparam logic [6:0] C_FJMP  = 7'b0000100;

  pipe_ctrl #(.MEM_TIMEOUT(8), .DRAIN_CYCLES(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .id_fence       (id_fence),
    .id_pc          (id_pc),
    .ex_rmem        (ex_rmem),
    .ex_wen         (ex_wen),
    .ex_rd_addr     (ex_rd_addr),
    .ex_jump        (ex_jump),
    .ex_jump_addr   (ex_jump_addr),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .hold_pc        (hold_pc),
    .hold_if_id     (hold_if_id),
    .hold_id_ex     (hold_id_ex),
    .hold_ex_mem    (hold_ex_mem),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .flush_mem_wb   (flush_mem_wb),
    .jump_o         (jump_o),
    .jump_addr_o    (jump_addr_o),
    .mem_err        (mem_err),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  // 10-time-unit clock; the DUT acts on the rising edge.
  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic applyStimulus(input logic mreq, input logic mrdy, input logic jmp,
                               input logic fence, input logic ld, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    @(negedge clk);
    mem_req     = mreq;
    mem_ready   = mrdy;
    ex_jump     = jmp;
    id_fence    = fence;
    ex_rmem     = ld;
    ex_wen      = ld;
    ex_rd_addr  = rd;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rs1_used = 1'b1;
    id_rs2_used = 1'b1;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Compare controls and perf counters, then account this cycle in the perf model.
  task automatic checkOutput(input string tag, input logic [6:0] ctl, input logic jmp,
                             input logic [31:0] addr, input logic err);
    logic [40:0] obs;
    logic [40:0] exp_v;
    logic [63:0] pobs;
    logic [63:0] pexp;
    obs   = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex,
             flush_mem_wb, jump_o, jump_addr_o, mem_err};
    exp_v = {ctl, jmp, addr, err};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
    pobs = {perf_stall_cnt, perf_flush_cnt};
`ifdef PIPE_CTRL_PERF_EN
    pexp = {exp_stall, exp_flush};
`else
    pexp = '0;
`endif
    checks++;
    assert (pobs === pexp) else begin
      errors++;
      $error("[TB] FAIL %s/perf: observed=%h expected=%h", tag, pobs, pexp);
    end
    exp_stall = exp_stall + 32'(ctl[6]);
    exp_flush = exp_flush + 32'(jmp);
  endtask

  initial begin
    $display("[TB] pipe_ctrl directed test start");

    // Outputs gated while reset is held, even with a jump presented.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5);
    checkOutput("rst_gate", C_NONE, 1'b0, 32'h0, 1'b0);
    #2;
    ex_jump = 1'b0;
    ex_rmem = 1'b0;
    ex_wen  = 1'b0;
    rst     = 1'b0;

    idleCycle();
    checkOutput("idle", C_NONE, 1'b0, 32'h0, 1'b0);

    // Load-use on rs2, then clear once the load moves on.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5);
    checkOutput("load_use_rs2", C_HAZ, 1'b0, 32'h0, 1'b0);
    idleCycle();
    checkOutput("lu_clear", C_NONE, 1'b0, 32'h0, 1'b0);

    // Load into x0 never stalls, even when ID reads x0.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("lu_x0", C_NONE, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3);
    checkOutput("load_use_rs1", C_HAZ, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd5, 5'd5);
    checkOutput("lu_nomatch", C_NONE, 1'b0, 32'h0, 1'b0);

    // Jump beats both a load-use hazard and a FENCE.I in ID.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd5);
    checkOutput("jump_over_hazard", C_JMP, 1'b1, 32'h8000_0100, 1'b0);

    // Four bus-wait cycles hold the jump, which fires on release.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("mem_wait", C_STALL, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("mem_release_jump", C_JMP, 1'b1, 32'h8000_0100, 1'b0);
    idleCycle();
    checkOutput("after_release", C_NONE, 1'b0, 32'h0, 1'b0);

    // Timeout: one entry cycle plus seven waiting cycles, error on MEM_WAIT cycle 8.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("tmo_wait", C_STALL, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("tmo_err", C_NONE, 1'b0, 32'h0, 1'b1);
    idleCycle();
    checkOutput("tmo_after", C_NONE, 1'b0, 32'h0, 1'b0);

    // Ready arriving on the timeout cycle wins: no error.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("tmo_ready_wait", C_STALL, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("tmo_ready", C_NONE, 1'b0, 32'h0, 1'b0);
    idleCycle();
    checkOutput("tmo_ready_after", C_NONE, 1'b0, 32'h0, 1'b0);

    // FENCE.I: three drain cycles, then redirect to id_pc+4.
    id_pc = 32'h0000_1000;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("fence_drain", C_HAZ, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("fence_redirect", C_FJMP, 1'b1, 32'h0000_1004, 1'b0);
    idleCycle();
    checkOutput("fence_after", C_NONE, 1'b0, 32'h0, 1'b0);

    // FENCE.I at the top of memory wraps to 0; a bus stall pauses the drain.
    id_pc = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("fence2_drain", C_HAZ, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("fence2_mem_pause", C_STALL, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("fence2_resume", C_HAZ, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("fence2_wrap", C_FJMP, 1'b1, 32'h0000_0000, 1'b0);
    idleCycle();
    checkOutput("fence2_after", C_NONE, 1'b0, 32'h0, 1'b0);

    // Reset mid-MEM_WAIT clears outputs at once and returns to RUN.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checkOutput("pre_rst_wait", C_STALL, 1'b0, 32'h0, 1'b0);
    end
    #1;
    rst       = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    #1;
    checkOutput("rst_async", C_NONE, 1'b0, 32'h0, 1'b0);
    mem_req = 1'b0;
    #1;
    rst = 1'b0;
    idleCycle();
    checkOutput("post_rst_run", C_NONE, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("post_rst_stall", C_STALL, 1'b0, 32'h0, 1'b0);
    idleCycle();
    checkOutput("post_rst_tail", C_STALL, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
